handshake_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream valid/ready channel among N upstream valid/ready requesters. Each requester behaves like our existing single-channel handshake master: it raises valid, holds its data, and drops valid after the ready handshake. The arbiter grants one requester per cycle, registers the winning word into a one-entry output stage, and tags it with the source index. It sits between a set of handshake masters and a single shared slave or datapath.

---
 rtl/handshake_rr_arbiter_if.sv | 26 ++
 rtl/handshake_rr_arbiter.sv | 109 ++++++++++
 tb/tb_handshake_rr_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/handshake_rr_arbiter_if.sv
// Shared bundle for the round-robin arbiter: N upstream valid/ready requesters
// and one downstream valid/ready channel tagged with the source index.
interface handshake_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  logic            busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, busy
  );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter: grants one requester per cycle into a one-entry
// registered output stage that carries the winning word and its source index.
module handshake_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int IW = $clog2(N)
) (
  input logic                  clk,
  input logic                  rst,
  handshake_rr_arbiter_if.slave bus
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [IW-1:0] out_id_q, out_id_d;

  logic          slot_free_s;
  logic          found_s;
  logic          accept_s;
  logic [IW-1:0] win_s;
  logic [IW:0]   idx_s;
  logic [N-1:0]  grant_s;
  logic [DW-1:0] win_data_s;

  assign slot_free_s = !out_valid_q || bus.out_ready;
  assign accept_s    = !rst && slot_free_s && found_s;

  // Winner search: first valid index from ptr upward, wrapping at N (not 2**IW)
  always_comb begin
    found_s = 1'b0;
    win_s   = {IW{1'b0}};
    idx_s   = {(IW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      idx_s = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx_s >= (IW+1)'(N)) begin
        idx_s = idx_s - (IW+1)'(N);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && bus.req_valid[idx_s[IW-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[IW-1:0];
      end else begin
        found_s = found_s;
        win_s   = win_s;
      end
    end
  end

  // One-hot grant and winning-word mux; the grant never looks at req_data
  always_comb begin
    grant_s    = {N{1'b0}};
    win_data_s = {DW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (win_s == IW'(i)) begin
        grant_s[i] = accept_s;
        win_data_s = bus.req_data[i*DW +: DW];
      end else begin
        grant_s[i] = 1'b0;
        win_data_s = win_data_s;
      end
    end
  end

  // Output stage next state: accept beats drain, backpressure freezes everything
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data_s;
      out_id_d    = win_s;
      if (win_s == IW'(N-1)) begin
        ptr_d = {IW{1'b0}};
      end else begin
        ptr_d = win_s + IW'(1'b1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset that discards any held word
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= {IW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {DW{1'b0}};
      out_id_q    <= {IW{1'b0}};
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.busy      = (|bus.req_valid) || out_valid_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench: an N=4 arbiter tracked by a scoreboard model, plus an
// N=3 instance for the non-power-of-two wrap.
module tb_handshake_rr_arbiter;

  logic clk = 1'b0;
  logic rst4;
  logic rst3;
  logic mon_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } sb_entry_t;

  sb_entry_t sb[$];

  logic       m_valid = 1'b0;
  int         m_ptr   = 0;
  logic       m_slot;
  logic       m_found;
  int         m_win;
  int         m_idx;
  logic [3:0] m_ready;
  sb_entry_t  m_ent;

  always #5 clk = ~clk;

  handshake_rr_arbiter_if #(.N(4), .DW(32)) if4 ();
  handshake_rr_arbiter_if #(.N(3), .DW(32)) if3 ();

  handshake_rr_arbiter #(.N(4), .DW(32)) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4)
  );

  handshake_rr_arbiter #(.N(3), .DW(32)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (if3)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_data4(input int i, input logic [31:0] v);
    if4.req_data[i*32 +: 32] = v;
  endtask

  // Reference model of the N=4 instance, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("busy", 64'(if4.busy), 64'((|if4.req_valid) || m_valid));
      check_eq("out_valid", 64'(if4.out_valid), 64'(m_valid));
      if (m_valid) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          check_eq("sb_id", 64'(if4.out_id), 64'(sb[0].id));
          check_eq("sb_data", 64'(if4.out_data), 64'(sb[0].data));
          if (if4.out_ready) m_ent = sb.pop_front();
        end
      end
      if (rst4) begin
        check_eq("rst_ready", 64'(if4.req_ready), 64'd0);
        sb.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
      end else begin
        m_slot  = !m_valid || if4.out_ready;
        m_found = 1'b0;
        m_win   = 0;
        for (int k = 0; k < 4; k++) begin
          m_idx = (m_ptr + k) % 4;
          if (!m_found && if4.req_valid[m_idx]) begin
            m_found = 1'b1;
            m_win   = m_idx;
          end
        end
        m_ready = 4'b0000;
        if (m_slot && m_found) m_ready[m_win] = 1'b1;
        check_eq("ready", 64'(if4.req_ready), 64'(m_ready));
        if (m_slot && m_found) begin
          m_ent.id   = m_win;
          m_ent.data = if4.req_data[m_win*32 +: 32];
          sb.push_back(m_ent);
          m_ptr   = (m_win + 1) % 4;
          m_valid = 1'b1;
        end else if (if4.out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  int exp3[4] = '{2, 0, 2, 0};

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    if4.req_valid = 4'b1111;
    if4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_data4(i, 32'h1000_0000 + 32'(i));
    if3.req_valid = 3'b000;
    if3.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) if3.req_data[i*32 +: 32] = 32'h3000_0000 + 32'(i);

    // Reset held two edges with every requester valid
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    neg();
    check_eq("rst_ready_d", 64'(if4.req_ready), 64'd0);
    check_eq("rst_valid_d", 64'(if4.out_valid), 64'd0);
    step();
    rst4 = 1'b0;
    rst3 = 1'b0;
    neg();
    check_eq("rst_data", 64'(if4.out_data), 64'd0);
    check_eq("rst_id", 64'(if4.out_id), 64'd0);
    check_eq("first_grant", 64'(if4.req_ready), 64'b0001);
    step();
    if4.req_valid = 4'b0000;
    step();

    // Single requester 2
    set_data4(2, 32'hA5A5_0002);
    if4.req_valid = 4'b0100;
    neg();
    check_eq("single_ready", 64'(if4.req_ready), 64'b0100);
    step();
    if4.req_valid = 4'b0000;
    neg();
    check_eq("single_valid", 64'(if4.out_valid), 64'd1);
    check_eq("single_data", 64'(if4.out_data), 64'hA5A5_0002);
    check_eq("single_id", 64'(if4.out_id), 64'd2);
    step();
    neg();
    check_eq("single_drain", 64'(if4.out_valid), 64'd0);
    step();
    if4.req_valid = 4'b1001;
    neg();
    check_eq("ptr_after_single", 64'(if4.req_ready), 64'b1000);
    step();
    if4.req_valid = 4'b0000;
    step();

    // Round-robin fairness, all valid, full throughput
    set_data4(2, 32'h1000_0002);
    if4.req_valid = 4'b1111;
    step();
    for (int i = 0; i < 6; i++) begin
      neg();
      check_eq("rr_id", 64'(if4.out_id), 64'(i % 4));
      check_eq("rr_valid", 64'(if4.out_valid), 64'd1);
      check_eq("rr_data", 64'(if4.out_data), 64'(32'h1000_0000 + 32'(i % 4)));
      step();
    end
    if4.req_valid = 4'b0000;
    step();

    // Backpressure after the first accept
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    if4.req_valid = 4'b1111;
    step();
    if4.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      neg();
      check_eq("bp_ready", 64'(if4.req_ready), 64'd0);
      check_eq("bp_data", 64'(if4.out_data), 64'h1000_0000);
      check_eq("bp_id", 64'(if4.out_id), 64'd0);
      step();
    end
    if4.out_ready = 1'b1;
    neg();
    check_eq("bp_release", 64'(if4.req_ready), 64'b0010);

    // Reset while a word is held under backpressure
    step();
    if4.out_ready = 1'b0;
    step();
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    neg();
    check_eq("midrst_valid", 64'(if4.out_valid), 64'd0);
    check_eq("midrst_ptr", 64'(if4.req_ready), 64'b0001);
    step();
    if4.req_valid = 4'b0000;
    if4.out_ready = 1'b1;
    step();
    step();

    // Non-power-of-two wrap on the N=3 instance, starting from ptr=2
    if3.req_valid = 3'b010;
    step();
    if3.req_valid = 3'b101;
    neg();
    check_eq("n3_ready", 64'(if3.req_ready), 64'b100);
    check_eq("n3_busy", 64'(if3.busy), 64'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      neg();
      check_eq("n3_id", 64'(if3.out_id), 64'(exp3[i]));
      check_eq("n3_valid", 64'(if3.out_valid), 64'd1);
      step();
    end
    if3.req_valid = 3'b000;

    // Random traffic against the scoreboard
    for (int c = 0; c < 300; c++) begin
      step();
      if4.req_valid = 4'($urandom_range(0, 15));
      if4.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) set_data4(i, 32'($urandom));
    end
    step();
    if4.req_valid = 4'b0000;
    if4.out_ready = 1'b1;
    step();
    step();
    neg();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
